// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load extract/extend, writeback select, decode bypass, retire counter.
// Latency: MEM inputs captured at edge N drive wb_* during the next cycle; the decode bypass is combinational.
// Backpressure: stall holds the register and the write repeats (idempotent); flush inserts a bubble and beats stall.
module wb_stage #(
   parameter bit FWD_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic        mem_reg_we,
   input  logic [4:0]  mem_rd,
   input  logic [1:0]  mem_wb_sel,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_pc,
   input  logic [31:0] mem_load_data,
   input  logic [2:0]  mem_load_type,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [31:0] id_raw_1,
   input  logic [31:0] id_raw_2,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        wb_valid,
   output logic        wb_misalign,
   output logic [31:0] id_data_1,
   output logic [31:0] id_data_2,
   output logic [31:0] retired_count
);

   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   localparam logic [2:0] LT_LH  = 3'd1;
   localparam logic [2:0] LT_LHU = 3'd2;
   localparam logic [2:0] LT_LB  = 3'd3;
   localparam logic [2:0] LT_LBU = 3'd4;

   // MEM/WB pipeline register contents
   logic        r_valid;
   logic        r_we;
   logic [4:0]  r_rd;
   logic [1:0]  r_sel;
   logic [2:0]  r_load_type;
   logic [31:0] r_pc;
   logic [31:0] r_alu_result;
   logic [31:0] r_load_data;
   logic [31:0] r_retired_count;

   logic [1:0]  w_addr_lo;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_val;
   logic        w_misaligned;
   logic [31:0] w_wb_data;
   logic        w_misalign;
   logic        w_we;
   logic        w_retire;

   assign w_addr_lo = r_alu_result[1:0];
   // An entry leaves the register only on an edge that neither holds nor flushes it
   assign w_retire  = r_valid & ~stall & ~flush;

   // MEM/WB register update: flush beats stall beats capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid      <= 1'b0;
         r_we         <= 1'b0;
         r_rd         <= 5'd0;
         r_sel        <= 2'b00;
         r_load_type  <= 3'd0;
         r_pc         <= 32'd0;
         r_alu_result <= 32'd0;
         r_load_data  <= 32'd0;
      end else if (flush) begin
         r_valid      <= 1'b0;
         r_we         <= 1'b0;
         r_rd         <= 5'd0;
         r_sel        <= 2'b00;
         r_load_type  <= 3'd0;
         r_pc         <= 32'd0;
         r_alu_result <= 32'd0;
         r_load_data  <= 32'd0;
      end else if (!stall) begin
         r_valid      <= mem_valid;
         r_we         <= mem_reg_we;
         r_rd         <= mem_rd;
         r_sel        <= mem_wb_sel;
         r_load_type  <= mem_load_type;
         r_pc         <= mem_pc;
         r_alu_result <= mem_alu_result;
         r_load_data  <= mem_load_data;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^32 (misaligned loads still retire)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired_count <= 32'd0;
      end else if (w_retire) begin
         r_retired_count <= r_retired_count + 32'd1;
      end
   end

   // Little-endian lane extraction and sign/zero extension of the loaded word
   always_comb begin
      w_byte     = 8'h00;
      w_half     = 16'h0000;
      w_load_val = r_load_data;
      case (w_addr_lo)
         2'd0:    w_byte = r_load_data[7:0];
         2'd1:    w_byte = r_load_data[15:8];
         2'd2:    w_byte = r_load_data[23:16];
         default: w_byte = r_load_data[31:24];
      endcase
      w_half = w_addr_lo[1] ? r_load_data[31:16] : r_load_data[15:0];
      case (r_load_type)
         LT_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
         LT_LBU:  w_load_val = {24'd0, w_byte};
         LT_LH:   w_load_val = {{16{w_half[15]}}, w_half};
         LT_LHU:  w_load_val = {16'd0, w_half};
         default: w_load_val = r_load_data;
      endcase
   end

   // Alignment check: bytes never fault, halves need an even address, words (and unknown types) need addr_lo=0
   always_comb begin
      w_misaligned = 1'b0;
      case (r_load_type)
         LT_LB, LT_LBU: w_misaligned = 1'b0;
         LT_LH, LT_LHU: w_misaligned = w_addr_lo[0];
         default:       w_misaligned = (w_addr_lo != 2'd0);
      endcase
   end

   // Writeback value select; code 11 falls back to the ALU result
   always_comb begin
      w_wb_data = r_alu_result;
      case (r_sel)
         SEL_LOAD: w_wb_data = w_load_val;
         SEL_LINK: w_wb_data = r_pc + 32'd8;
         default:  w_wb_data = r_alu_result;
      endcase
   end

   assign w_misalign = r_valid & (r_sel == SEL_LOAD) & w_misaligned;
   // r0 is hard-wired zero, so its writes are dropped here and hence never bypassed
   assign w_we       = r_valid & r_we & (r_rd != 5'd0) & ~w_misalign;

   assign wb_we         = w_we;
   assign wb_addr       = r_rd;
   assign wb_data       = w_wb_data;
   assign wb_valid      = r_valid;
   assign wb_misalign   = w_misalign;
   assign retired_count = r_retired_count;

   // Write-through bypass so a decode read in the commit cycle sees the new value
   assign id_data_1 = (FWD_EN && w_we && (r_rd == id_rs1)) ? w_wb_data : id_raw_1;
   assign id_data_2 = (FWD_EN && w_we && (r_rd == id_rs2)) ? w_wb_data : id_raw_2;

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage MIPS pipeline. It holds the MEM/WB pipeline register, extracts and extends load data, and selects the writeback value. It drives the write port of the general-purpose register file and supplies a write-through bypass to the decode-stage read ports. It also keeps a retired-instruction counter.

## Interface
Parameters:
- FWD_EN, 1, 1 enables the decode-read bypass; 0 passes the raw register-file data through.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- stall  in  1  holds the MEM/WB register
- flush  in  1  loads a bubble into the MEM/WB register
- mem_valid  in  1  MEM stage holds a real instruction
- mem_reg_we  in  1  instruction writes a GPR
- mem_rd  in  5  destination register
- mem_wb_sel  in  2  00 ALU result, 01 load data, 10 link (pc+8), 11 treated as 00
- mem_alu_result  in  32  ALU result, also the load address
- mem_pc  in  32  instruction PC
- mem_load_data  in  32  raw word read from data memory
- mem_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW
- id_rs1, id_rs2  in  5  decode read addresses
- id_raw_1, id_raw_2  in  32  register-file read data
- wb_we  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  32  register-file write data
- wb_valid  out  1  MEM/WB register holds a real instruction
- wb_misalign  out  1  registered load is misaligned; its write is suppressed
- id_data_1, id_data_2  out  32  bypassed decode operands
- retired_count  out  32  count of retired instructions

## Operation
- **MEM/WB register update at each rising edge** (priority order):
  - flush: bubble; valid=0, we=0, all fields 0.
  - else stall: hold all fields.
  - else capture: valid, we, rd, sel, load_type, pc, alu_result, load_data.
- **Load lanes:** little-endian, addr_lo = alu_result[1:0]. Byte lane k is bits 8k+7:8k. Half lane 0 is bits 15:0 and half lane 1 is bits 31:16, selected by addr_lo[1].
- **Load extension:**
  - LB and LH sign-extend to 32 bits.
  - LBU and LHU zero-extend to 32 bits.
  - LW takes the whole word.
- **Misalignment** applies only when sel=01:
  - LW with addr_lo≠0 is misaligned.
  - LH or LHU with addr_lo[0]=1 is misaligned.
  - wb_misalign = valid & sel==01 & misaligned condition.
- **Write data:** wb_data = selected value. Link = pc + 8, computed mod 2^32.
- **Write enable:** wb_we = valid & we & (rd≠0) & !wb_misalign.
- **Write address:** wb_addr = registered rd.
- **Bypass** (FWD_EN=1): id_data_n = wb_data when wb_we & wb_addr==id_rsn; otherwise id_raw_n. This path is combinational.
- **Retire counter:**
  - Increments at every edge where stall=0, flush=0 and the register holds valid=1; that entry is retiring.
  - Misaligned loads count as retired.
  - Wraps 0xFFFFFFFF → 0.

## Timing
- **Reset:** assertion clears immediately, without waiting for clk, every state bit. The outputs then read:
  - wb_we=0, wb_addr=0, wb_data=0, wb_valid=0, wb_misalign=0, retired_count=0.
  - id_data_n = id_raw_n.
- **Reset mid-operation:** any in-flight entry is discarded and its write never happens.
- **Latency:** MEM-stage inputs captured at edge N appear on wb_* during cycle N..N+1. The register file commits them at edge N+1.
- **Same-cycle read:** a decode read during that cycle sees the new value through the bypass.
- **stall and flush together:** flush wins.
- **Stall holds the write:** under stall, wb_we stays asserted and the same write repeats each cycle. This is harmless because the write is idempotent.
- **Retirement edge:** retired_count updates at the edge the entry leaves the register. It is visible the following cycle.
- **Register 0:** writes to rd=0 are never enabled and never bypassed, even with we=1.

## Test plan
- **Reset:** assert rst_n=0 between edges.
  - Required: all outputs go to 0 before the next edge.
  - Required: id_data_1 follows id_raw_1=0x1234.
- **Signed load extension:** LB with load_data=0x80FF7F01 and alu_result=…02.
  - Required: wb_data=0xFFFFFFFF, wb_we=1.
  - With LBU the same stimulus gives wb_data=0x000000FF.
  - LH with addr …02 gives 0xFFFF80FF; LHU gives 0x000080FF.
- **Misaligned load and r0 suppression:**
  - LW at addr …01, rd=5: wb_misalign=1 and wb_we=0.
  - ALU write with rd=0 and value 0x55: wb_we=0.
- **Link:** sel=10, pc=0xFFFFFFFC.
  - Required: wb_data=0x00000004.
- **Bypass:** wb writes rd=7 with 0xDEADBEEF while id_rs1=7, id_raw_1=0.
  - Required: id_data_1=0xDEADBEEF.
  - id_rs2=8 must pass id_raw_2 through.
  - With FWD_EN=0, id_data_1=0.
- **Stall, flush and counter:** retire 3 valid instructions, stall 2 cycles, then assert flush together with stall.
  - Required: retired_count=3 after the stall and the held entry is discarded.
  - Required: preloading the counter to 0xFFFFFFFF and retiring one instruction gives retired_count=0.
